// File: rtl/button_cmd_ctrl_if.sv
// Button/command bundle between the front-panel debouncers, the arbiter
// and the mode/edit state machine.
interface button_cmd_ctrl_if #(
    parameter int N_BTN = 5,
    parameter int IDW   = $clog2(N_BTN)
);
    logic [N_BTN-1:0] btn_level;
    logic             en;
    logic             cmd_valid;
    logic [IDW-1:0]   cmd_id;
    logic             cmd_repeat;
    logic             busy;

    modport master (
        output btn_level, en,
        input  cmd_valid, cmd_id, cmd_repeat, busy
    );

    modport slave (
        input  btn_level, en,
        output cmd_valid, cmd_id, cmd_repeat, busy
    );
endinterface

// File: rtl/button_cmd_ctrl.sv
// Single-owner button arbiter: turns debounced levels into one-cycle command
// pulses with hold-delay auto-repeat; a new press needs a full release first.
module button_cmd_ctrl #(
    parameter int N_BTN      = 5,
    parameter int HOLD_CYC   = 100_000_000,
    parameter int REPEAT_CYC = 20_000_000,
    parameter int IDW        = $clog2(N_BTN)
) (
    input logic              clk,
    input logic              reset,
    button_cmd_ctrl_if.slave bus
);
    localparam int MAX_CYC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int CW      = $clog2(MAX_CYC);
    localparam logic [CW-1:0] HOLD_TC   = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYC - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT_ALL} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic           valid_q, valid_d;
    logic           rep_q, rep_d;

    logic           any_btn;
    logic           owner_lvl;
    logic           keep_owner;
    logic           at_tc;
    logic           grant;
    logic           found;
    logic [IDW-1:0] low_idx;

    always_comb begin
        low_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (!found && bus.btn_level[i]) begin
                low_idx = IDW'(i);
                found   = 1'b1;
            end
        end
    end

    assign any_btn    = |bus.btn_level;
    assign owner_lvl  = bus.btn_level[id_q];
    assign keep_owner = owner_lvl && bus.en;
    assign grant      = bus.en && any_btn;
    assign at_tc      = (state_q == HOLD) ? (cnt_q == HOLD_TC) : (cnt_q == REPEAT_TC);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_ALL;
            cnt_q   <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            rep_q   <= rep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (grant) state_d = HOLD;
            HOLD,
            REPEAT: begin
                // Release or disable wins over a coincident terminal count.
                if (!keep_owner) state_d = WAIT_ALL;
                else if (at_tc)  state_d = REPEAT;
            end
            WAIT_ALL:    if (!any_btn) state_d = IDLE;
            default:     state_d = WAIT_ALL;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        id_d    = id_q;
        valid_d = 1'b0;
        rep_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    id_d    = low_idx;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                end
            end
            HOLD,
            REPEAT: begin
                if (keep_owner) begin
                    if (at_tc) begin
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        rep_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.cmd_valid  = valid_q;
    assign bus.cmd_repeat = rep_q;
    assign bus.cmd_id     = id_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_button_cmd_ctrl.sv
// Directed plus randomized bench for button_cmd_ctrl against a time-stamp
// based reference model of the press/hold/repeat/release rules.
module tb_button_cmd_ctrl;
    localparam int NB  = 5;
    localparam int HC  = 8;
    localparam int RC  = 3;
    localparam int IW  = $clog2(NB);

    localparam int PH_IDLE = 0;
    localparam int PH_OWN  = 1;
    localparam int PH_WAIT = 2;

    logic clk = 1'b0;
    logic reset;

    button_cmd_ctrl_if #(.N_BTN(NB)) bus ();

    button_cmd_ctrl #(
        .N_BTN(NB),
        .HOLD_CYC(HC),
        .REPEAT_CYC(RC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;

    // reference model state
    int          m_phase = PH_WAIT;
    int          m_owner = 0;
    int          m_first = 0;
    int          cyc     = 0;
    logic        exp_valid = 1'b0;
    logic        exp_rep   = 1'b0;
    logic        exp_busy  = 1'b1;
    logic [IW-1:0] exp_id  = '0;

    function automatic int lowest(input logic [NB-1:0] b);
        for (int i = 0; i < NB; i++) if (b[i]) return i;
        return 0;
    endfunction

    // Advance the model across one clock edge using the inputs as sampled there.
    task automatic model_step();
        int n;
        exp_valid = 1'b0;
        exp_rep   = 1'b0;
        if (reset) begin
            m_phase = PH_WAIT;
            exp_id  = '0;
        end else begin
            case (m_phase)
                PH_IDLE: if (bus.en && bus.btn_level != '0) begin
                    m_owner   = lowest(bus.btn_level);
                    exp_id    = IW'(m_owner);
                    m_first   = cyc + 1;
                    exp_valid = 1'b1;
                    m_phase   = PH_OWN;
                end
                PH_OWN: begin
                    if (!bus.btn_level[m_owner] || !bus.en) begin
                        m_phase = PH_WAIT;
                    end else begin
                        n = cyc + 1 - m_first;
                        if (n == HC || (n > HC && (n - HC) % RC == 0)) begin
                            exp_valid = 1'b1;
                            exp_rep   = 1'b1;
                        end
                    end
                end
                default: if (bus.btn_level == '0) m_phase = PH_IDLE;
            endcase
        end
        exp_busy = (m_phase != PH_IDLE);
        cyc++;
    endtask

    task automatic check_outputs();
        if (bus.cmd_valid === 1'b1) pulses++;
        n_tests++;
        assert (bus.cmd_valid === exp_valid) else begin
            n_fail++;
            $error("FAIL cmd_valid cyc=%0d observed=%0b expected=%0b", cyc, bus.cmd_valid, exp_valid);
        end
        n_tests++;
        assert (bus.busy === exp_busy) else begin
            n_fail++;
            $error("FAIL busy cyc=%0d observed=%0b expected=%0b", cyc, bus.busy, exp_busy);
        end
        if (exp_valid) begin
            n_tests++;
            assert (bus.cmd_repeat === exp_rep) else begin
                n_fail++;
                $error("FAIL cmd_repeat cyc=%0d observed=%0b expected=%0b", cyc, bus.cmd_repeat, exp_rep);
            end
        end
        if (exp_valid || exp_busy) begin
            n_tests++;
            assert (bus.cmd_id === exp_id) else begin
                n_fail++;
                $error("FAIL cmd_id cyc=%0d observed=%0d expected=%0d", cyc, bus.cmd_id, exp_id);
            end
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk);
            #1;
            check_outputs();
        end
    endtask

    task automatic drive(input logic [NB-1:0] b, input logic e, input logic r);
        bus.btn_level = b;
        bus.en        = e;
        reset         = r;
    endtask

    task automatic check_pulses(input string tag, input int want);
        n_tests++;
        assert (pulses === want) else begin
            n_fail++;
            $error("FAIL %s pulse_count observed=%0d expected=%0d", tag, pulses, want);
        end
        pulses = 0;
    endtask

    initial begin
        logic [NB-1:0] rb;
        int            sel;
        drive('0, 1'b1, 1'b1);
        #1;
        tick(3);
        drive('0, 1'b1, 1'b0);
        tick(3);
        check_pulses("reset", 0);

        drive(5'b00100, 1'b1, 1'b0);
        tick(4);
        drive('0, 1'b1, 1'b0);
        tick(4);
        check_pulses("short_press", 1);

        drive(5'b00010, 1'b1, 1'b0);
        tick(20);
        drive('0, 1'b1, 1'b0);
        tick(3);
        check_pulses("long_hold", 5);

        drive(5'b01001, 1'b1, 1'b0);
        tick(3);
        drive(5'b01000, 1'b1, 1'b0);
        tick(6);
        drive('0, 1'b1, 1'b0);
        tick(3);
        check_pulses("chord", 1);

        drive(5'b10000, 1'b1, 1'b0);
        tick(8);
        drive('0, 1'b1, 1'b0);
        tick(4);
        check_pulses("release_on_tc", 1);

        drive(5'b00001, 1'b1, 1'b0);
        tick(4);
        drive(5'b00001, 1'b0, 1'b0);
        tick(12);
        drive('0, 1'b1, 1'b0);
        tick(3);
        check_pulses("en_drop", 1);

        drive(5'b00100, 1'b1, 1'b0);
        tick(12);
        pulses = 0;
        drive(5'b00100, 1'b1, 1'b1);
        tick(2);
        drive(5'b00100, 1'b1, 1'b0);
        tick(10);
        check_pulses("reset_mid_repeat", 0);
        drive('0, 1'b1, 1'b0);
        tick(3);
        drive(5'b00100, 1'b1, 1'b0);
        tick(2);
        drive('0, 1'b1, 1'b0);
        tick(3);
        check_pulses("repress_after_reset", 1);

        drive(5'b00010, 1'b0, 1'b0);
        tick(3);
        drive(5'b00010, 1'b1, 1'b0);
        tick(2);
        drive('0, 1'b1, 1'b0);
        tick(3);
        check_pulses("en_rise_held", 1);

        for (int seg = 0; seg < 300; seg++) begin
            sel = int'($urandom_range(0, 9));
            rb  = NB'($urandom);
            if (sel < 3)      rb = '0;
            else if (sel < 7) rb = NB'(1) << $urandom_range(0, NB - 1);
            drive(rb, ($urandom_range(0, 7) != 0), ($urandom_range(0, 39) == 0));
            tick(int'($urandom_range(1, 25)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/button_cmd_ctrl.md
# button_cmd_ctrl

Arbitrates the debounced button levels of the alarm clock front panel and turns them into single-cycle command pulses for the time/alarm edit logic. At most one button owns the controller at a time. A held button auto-repeats after a hold delay. A new press is accepted only after all buttons have been released. The block sits between the per-button debouncers and the mode/edit state machine, in the `clk` domain.

## Interface
- `N_BTN`, default 5: number of button inputs, 2..8.
- `HOLD_CYC`, default 100_000_000: cycles from the first pulse to the first auto-repeat pulse (1 s at 100 MHz). Must be ≥ 2.
- `REPEAT_CYC`, default 20_000_000: cycles between auto-repeat pulses. Must be ≥ 2.
- `IDW`, default $clog2(N_BTN): width of `cmd_id`.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `btn_level` in N_BTN: debounced button levels, 1 = pressed. Already synchronous to `clk`.
- `en` in 1: 1 allows grants and pulses; 0 suppresses them.
- `cmd_valid` out 1: one-cycle command pulse.
- `cmd_id` out IDW: index of the owning button. Valid while `busy` = 1 and on every `cmd_valid` cycle.
- `cmd_repeat` out 1: 0 on the first pulse of a press, 1 on auto-repeat pulses. Meaningful only when `cmd_valid` = 1.
- `busy` out 1: 1 when the state is anything other than IDLE.

## Operation
- States: IDLE, HOLD, REPEAT, WAIT_ALL.
- **IDLE**
  - If `en` = 1 and `btn_level` ≠ 0, grant the lowest-indexed set bit.
  - Latch its index into `cmd_id`, clear the interval counter, go to HOLD.
  - Register `cmd_valid` = 1 and `cmd_repeat` = 0 for exactly one cycle.
- **HOLD**
  - Counter increments every cycle.
  - Owner bit low, or `en` low: go to WAIT_ALL, no pulse.
  - Counter reaching HOLD_CYC−1 with owner still high: emit a pulse with `cmd_repeat` = 1, clear the counter, go to REPEAT.
- **REPEAT**
  - Same as HOLD, but the terminal count is REPEAT_CYC−1.
  - Each terminal count emits a repeat pulse and clears the counter.
- **WAIT_ALL**
  - Stay until `btn_level` == 0, then go to IDLE on the next cycle.
  - No pulses in this state.
- Non-owner buttons are ignored in HOLD and REPEAT, including presses and releases.
- Chords never generate a second command.
- The counter is wide enough for max(HOLD_CYC, REPEAT_CYC)−1.
- The counter never wraps: it is cleared on every terminal count and on every grant.

## Timing
- **Reset**
  - `cmd_valid` = 0, `cmd_repeat` = 0, `cmd_id` = 0, counter = 0.
  - State = WAIT_ALL, so `busy` = 1.
  - A button held through reset therefore never fires.
  - With all buttons released, IDLE is reached 1 cycle after reset deasserts.
- **Grant latency:** with `btn_level` going non-zero in IDLE at cycle t, `cmd_valid` is high at t+1 and `busy` is high from t+1.
- **Repeat pulses:** let the first pulse be at cycle P. With the owner held continuously and `en` = 1, repeat pulses occur at:
  - P+HOLD_CYC,
  - then P+HOLD_CYC+k·REPEAT_CYC for k = 1, 2, ….
- **Release:** the owner bit sampled low at cycle r gives state WAIT_ALL at r+1.
  - A terminal count coinciding with r is suppressed: release wins.
  - The same rule applies to `en` sampled low.
- **Simultaneous presses in IDLE:** the lowest index wins. The others are never reported for that press.
- **Re-press:** a press in the same cycle that WAIT_ALL sees all-released is not granted until the cycle after IDLE is entered. Minimum press-to-press spacing is 3 cycles.
- **`en` low in IDLE:** presses are not granted. If `en` rises while a button is already held, that button is granted on the next cycle.
- **Reset mid-press:** any pending pulse is dropped, and the block follows the reset behaviour above.

## Test plan
Benches use `HOLD_CYC` = 8, `REPEAT_CYC` = 3, `N_BTN` = 5.
1. **Reset:** assert reset, then release it with `btn_level` = 0 → `busy` drops 1 cycle after reset deasserts. No `cmd_valid` ever appears.
2. **Short press:** hold `btn_level` = 5'b00100 for 4 cycles → one pulse, `cmd_id` = 2, `cmd_repeat` = 0, at t+1. `busy` returns low 2 cycles after release.
3. **Long hold:** hold bit 1 for 20 cycles → pulses at P (repeat = 0), then P+8, P+11, P+14, P+17 (repeat = 1), all with `cmd_id` = 1.
4. **Chord:** raise bits 3 and 0 in the same cycle → one pulse with `cmd_id` = 0. Drop bit 0 while bit 3 is still held → no further pulses. IDLE is reached only after bit 3 drops.
5. **Release on terminal count:** drop the owner exactly at cycle P+7 → no pulse at P+8.
6. **`en` and reset interference**
   - Drop `en` at P+3 → no repeat pulses.
   - Assert reset during REPEAT with the button held → no pulses until the button is released and pressed again.
